hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Producer of all pipeline stall, flush and forwarding controls for the 5-stage core.
- Drives the F/D, D/E, E/M and M/W register enables and flushes, plus E-stage operand forwarding selects.
- Holds a small FSM that freezes the whole pipeline while the data memory handshake is outstanding, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, cycles in MEM_WAIT before timeout_err sets (range 2..65535).
- CNT_W, 16, width of wait counter.

Ports:
- clk  in  1  clock; FSM and counters update on posedge.
- rst  in  1  asynchronous active-high reset.
- D_ra, D_rb  in  5 each  source registers of instruction in Decode.
- E_ra, E_rb  in  5 each  source registers of instruction in Execute.
- E_rd  in  5  destination register in Execute.
- E_RegWrite  in  1  Execute instruction writes the register file.
- E_result_src  in  2  Execute result select; 2'b01 = load.
- E_PCSrc  in  1  branch taken or jump resolved in Execute.
- M_rd, W_rd  in  5 each  destination registers in Memory and Writeback.
- M_RegWrite, W_RegWrite  in  1 each  write flags in Memory and Writeback.
- M_mem_access  in  1  Memory stage holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- F_en  out  1  PC enable.
- F_D_en, D_E_en, E_M_en, M_W_en  out  1 each  pipeline register enables.
- F_D_flush  out  1  bubble into F/D.
- CTRL_Flush  out  1  bubble into D/E.
- fwdA, fwdB  out  2 each  E operand select: 00 regfile, 01 W result, 10 M result.
- timeout_err  out  1  sticky memory-wait timeout flag.

Behaviour:
- Reset (rst=1, asynchronous): state=RUN, wait_cnt=0, timeout_err=0.
- While rst=1, all enables=0, F_D_flush=0, CTRL_Flush=0, fwdA=fwdB=00.
- All outputs except timeout_err are combinational from inputs and state. timeout_err is registered.
- freeze = M_mem_access & !mem_ready.
  - While freeze=1: all five enables=0, both flushes=0.
  - freeze has highest priority and masks load-use and branch handling.
  - A taken branch held during a freeze is applied in the first cycle after freeze drops, because E_PCSrc is still held.
- Branch (E_PCSrc=1, no freeze): F_D_flush=1, CTRL_Flush=1, all enables=1. Overrides load-use.
- Load-use (no freeze, no branch):
  - Condition: E_result_src=01, E_RegWrite=1, E_rd!=0, and E_rd equal to D_ra or D_rb.
  - Response: F_en=0, F_D_en=0, D_E_en=1, CTRL_Flush=1, E_M_en=M_W_en=1.
  - Lasts exactly one cycle, because the bubble clears the condition.
- Otherwise: all enables=1, both flushes=0.
- Forwarding, evaluated independently of stalls; M has priority over W:
  - fwdA=10 if M_RegWrite, M_rd!=0 and M_rd==E_ra.
  - Else fwdA=01 if W_RegWrite, W_rd!=0 and W_rd==E_ra.
  - Else fwdA=00.
  - fwdB uses the same rules with E_rb.
  - Register x0 never forwards.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when freeze=1; wait_cnt<=1.
  - MEM_WAIT: wait_cnt increments and saturates at all-ones.
  - MEM_WAIT -> RUN when freeze=0; wait_cnt<=0.
  - When wait_cnt reaches MEM_TIMEOUT, timeout_err<=1. It is sticky until rst, and the FSM stays in MEM_WAIT.
  - A single-cycle miss (mem_ready returns on the next cycle) costs exactly one frozen cycle.
- Reset mid-wait: the FSM returns to RUN immediately and outputs take their reset values.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds three 32-bit output counters, cleared by rst and wrapping at 2^32:
  - stall_cycles: increments on load-use cycles.
  - flush_events: increments on branch flush cycles.
  - freeze_cycles: increments while freeze=1.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: E load to x5 (E_result_src=01, E_RegWrite=1, E_rd=5), D_ra=5 -> one cycle of F_en=0, F_D_en=0, CTRL_Flush=1, D_E_en=1; next cycle, with E as a bubble, all enables=1.
- Branch plus load-use in the same cycle: E_PCSrc=1 with load-use condition true -> F_D_flush=1, CTRL_Flush=1, F_en=1.
- Forwarding: M_rd=W_rd=E_ra=7, both RegWrite=1 -> fwdA=10. With E_ra=0 and all rd=0 -> fwdA=00. W_rd=E_rb=3, M_rd=4 -> fwdB=01.
- Memory freeze: M_mem_access=1, mem_ready=0 for 3 cycles then 1 -> all enables=0 for 3 cycles, state MEM_WAIT, wait_cnt reaches 3, then RUN; a pending E_PCSrc is flushed on the release cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> timeout_err rises after 4 cycles in MEM_WAIT and stays 1 after mem_ready=1 until rst pulse.
- Async reset during MEM_WAIT: assert rst between clock edges -> outputs reach reset values without waiting for a clock edge; state=RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush/forwarding control with data-memory freeze
//            FSM and wait watchdog. Optional HAZ_PERF_CNT_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] D_ra,
   input  logic [4:0] D_rb,
   input  logic [4:0] E_ra,
   input  logic [4:0] E_rb,
   input  logic [4:0] E_rd,
   input  logic       E_RegWrite,
   input  logic [1:0] E_result_src,
   input  logic       E_PCSrc,
   input  logic [4:0] M_rd,
   input  logic [4:0] W_rd,
   input  logic       M_RegWrite,
   input  logic       W_RegWrite,
   input  logic       M_mem_access,
   input  logic       mem_ready,
   output logic       F_en,
   output logic       F_D_en,
   output logic       D_E_en,
   output logic       E_M_en,
   output logic       M_W_en,
   output logic       F_D_flush,
   output logic       CTRL_Flush,
   output logic [1:0] fwdA,
   output logic [1:0] fwdB,
   output logic       timeout_err
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
   output logic [31:0] freeze_cycles
`endif
);

   localparam logic [0:0]       c_ST_RUN      = 1'b0;
   localparam logic [0:0]       c_ST_MEM_WAIT = 1'b1;
   localparam logic [1:0]       c_SRC_LOAD    = 2'b01;
   localparam logic [1:0]       c_FWD_RF      = 2'b00;
   localparam logic [1:0]       c_FWD_W       = 2'b01;
   localparam logic [1:0]       c_FWD_M       = 2'b10;
   localparam logic [CNT_W-1:0] c_TIMEOUT     = CNT_W'(MEM_TIMEOUT);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout_err;

   logic w_freeze;
   logic w_branch;
   logic w_load_use;

   assign w_freeze   = M_mem_access & ~mem_ready;
   assign w_branch   = E_PCSrc & ~w_freeze;
   assign w_load_use = ~w_freeze & ~E_PCSrc
                     & (E_result_src == c_SRC_LOAD) & E_RegWrite
                     & (E_rd != 5'd0) & ((E_rd == D_ra) | (E_rd == D_rb));

   // M result is newer than W, so it wins; x0 is hard-wired and never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_rd, input logic m_we,
                                          input logic [4:0] w_rd, input logic w_we);
      logic [1:0] sel;
      sel = c_FWD_RF;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs))
         sel = c_FWD_M;
      else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
         sel = c_FWD_W;
      return sel;
   endfunction

   always_comb begin
      F_en       = 1'b1;
      F_D_en     = 1'b1;
      D_E_en     = 1'b1;
      E_M_en     = 1'b1;
      M_W_en     = 1'b1;
      F_D_flush  = 1'b0;
      CTRL_Flush = 1'b0;
      fwdA       = fwd_sel(E_ra, M_rd, M_RegWrite, W_rd, W_RegWrite);
      fwdB       = fwd_sel(E_rb, M_rd, M_RegWrite, W_rd, W_RegWrite);
      // Reset is asynchronous, so the combinational outputs must honour it too.
      if (rst) begin
         F_en   = 1'b0;
         F_D_en = 1'b0;
         D_E_en = 1'b0;
         E_M_en = 1'b0;
         M_W_en = 1'b0;
         fwdA   = c_FWD_RF;
         fwdB   = c_FWD_RF;
      end else if (w_freeze) begin
         F_en   = 1'b0;
         F_D_en = 1'b0;
         D_E_en = 1'b0;
         E_M_en = 1'b0;
         M_W_en = 1'b0;
      end else if (w_branch) begin
         F_D_flush  = 1'b1;
         CTRL_Flush = 1'b1;
      end else if (w_load_use) begin
         F_en       = 1'b0;
         F_D_en     = 1'b0;
         CTRL_Flush = 1'b1;
      end
   end

   // The watchdog only flags the condition; the wait itself is never aborted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_ST_RUN;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            c_ST_RUN: begin
               if (w_freeze) begin
                  r_state    <= c_ST_MEM_WAIT;
                  r_wait_cnt <= CNT_W'(1);
               end
            end
            c_ST_MEM_WAIT: begin
               if (r_wait_cnt >= c_TIMEOUT)
                  r_timeout_err <= 1'b1;
               if (w_freeze) begin
                  if (r_wait_cnt != {CNT_W{1'b1}})
                     r_wait_cnt <= r_wait_cnt + CNT_W'(1);
               end else begin
                  r_state    <= c_ST_RUN;
                  r_wait_cnt <= '0;
               end
            end
            default: begin
               r_state    <= c_ST_RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   assign timeout_err = r_timeout_err;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles  <= '0;
         flush_events  <= '0;
         freeze_cycles <= '0;
      end else begin
         if (w_load_use)
            stall_cycles <= stall_cycles + 32'd1;
         if (w_branch)
            flush_events <= flush_events + 32'd1;
         if (w_freeze)
            freeze_cycles <= freeze_cycles + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

   localparam int c_TO = 4;

   logic       clk;
   logic       rst;
   logic [4:0] D_ra, D_rb, E_ra, E_rb, E_rd, M_rd, W_rd;
   logic       E_RegWrite, E_PCSrc, M_RegWrite, W_RegWrite, M_mem_access, mem_ready;
   logic [1:0] E_result_src;
   logic       F_en, F_D_en, D_E_en, E_M_en, M_W_en, F_D_flush, CTRL_Flush, timeout_err;
   logic [1:0] fwdA, fwdB;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events, freeze_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit run_chk  = 1'b0;

   // Model state: consecutive frozen cycles seen so far, and the sticky flag.
   int m_run;
   bit m_err;

   hazard_ctrl #(.MEM_TIMEOUT(c_TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .D_ra(D_ra), .D_rb(D_rb), .E_ra(E_ra), .E_rb(E_rb), .E_rd(E_rd),
      .E_RegWrite(E_RegWrite), .E_result_src(E_result_src), .E_PCSrc(E_PCSrc),
      .M_rd(M_rd), .W_rd(W_rd), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
      .M_mem_access(M_mem_access), .mem_ready(mem_ready),
      .F_en(F_en), .F_D_en(F_D_en), .D_E_en(D_E_en), .E_M_en(E_M_en), .M_W_en(M_W_en),
      .F_D_flush(F_D_flush), .CTRL_Flush(CTRL_Flush), .fwdA(fwdA), .fwdB(fwdB),
      .timeout_err(timeout_err)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events), .freeze_cycles(freeze_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0;
         m_err = 1'b0;
      end else begin
         if (m_run >= c_TO) m_err = 1'b1;
         if (M_mem_access && !mem_ready) m_run = m_run + 1;
         else m_run = 0;
      end
   end

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (M_RegWrite && M_rd != 0 && M_rd == rs) return 2'b10;
      if (W_RegWrite && W_rd != 0 && W_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Vector order: {F_en, F_D_en, D_E_en, E_M_en, M_W_en, F_D_flush, CTRL_Flush}
   always @(negedge clk) begin
      if (run_chk) begin
         logic [6:0] e;
         logic       lu;
         lu = (E_result_src == 2'b01) && E_RegWrite && E_rd != 0 &&
              (E_rd == D_ra || E_rd == D_rb);
         if (rst)                            e = 7'b0000000;
         else if (M_mem_access && !mem_ready) e = 7'b0000000;
         else if (E_PCSrc)                   e = 7'b1111111;
         else if (lu)                        e = 7'b0011101;
         else                                e = 7'b1111100;
         chk("ctrl_vec", {25'd0, F_en, F_D_en, D_E_en, E_M_en, M_W_en, F_D_flush, CTRL_Flush},
             {25'd0, e});
         chk("fwdA", {30'd0, fwdA}, {30'd0, rst ? 2'b00 : exp_fwd(E_ra)});
         chk("fwdB", {30'd0, fwdB}, {30'd0, rst ? 2'b00 : exp_fwd(E_rb)});
         chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
      end
   end

   task automatic idle();
      D_ra = 5'd1; D_rb = 5'd2; E_ra = 5'd3; E_rb = 5'd4; E_rd = 5'd10;
      E_RegWrite = 1'b0; E_result_src = 2'b00; E_PCSrc = 1'b0;
      M_rd = 5'd11; W_rd = 5'd12; M_RegWrite = 1'b0; W_RegWrite = 1'b0;
      M_mem_access = 1'b0; mem_ready = 1'b1;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      E_ra = 5'd7; M_rd = 5'd7; M_RegWrite = 1'b1;
      M_mem_access = 1'b1; mem_ready = 1'b0;
      run_chk = 1'b1;
      sample();
      chk("rst_F_en", {31'd0, F_en}, 32'd0);
      chk("rst_fwdA", {30'd0, fwdA}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
      next(); rst = 1'b0; idle();

      // Load-use on D_ra, then the bubble it created
      E_result_src = 2'b01; E_RegWrite = 1'b1; E_rd = 5'd5; D_ra = 5'd5;
      sample();
      chk("lu_F_en", {31'd0, F_en}, 32'd0);
      chk("lu_F_D_en", {31'd0, F_D_en}, 32'd0);
      chk("lu_CTRL_Flush", {31'd0, CTRL_Flush}, 32'd1);
      chk("lu_D_E_en", {31'd0, D_E_en}, 32'd1);
      next(); E_result_src = 2'b00; E_RegWrite = 1'b0; E_rd = 5'd0;
      sample();
      chk("bubble_F_en", {31'd0, F_en}, 32'd1);
      chk("bubble_CTRL_Flush", {31'd0, CTRL_Flush}, 32'd0);
      // Load-use via D_rb, and a load to x0 which must not stall
      next(); E_result_src = 2'b01; E_RegWrite = 1'b1; E_rd = 5'd9; D_rb = 5'd9;
      sample();
      chk("lu_rb_F_en", {31'd0, F_en}, 32'd0);
      next(); E_rd = 5'd0; D_ra = 5'd0;
      sample();
      chk("lu_x0_F_en", {31'd0, F_en}, 32'd1);
      // Branch with load-use true at the same time
      next(); E_rd = 5'd5; D_ra = 5'd5; E_PCSrc = 1'b1;
      sample();
      chk("br_F_D_flush", {31'd0, F_D_flush}, 32'd1);
      chk("br_CTRL_Flush", {31'd0, CTRL_Flush}, 32'd1);
      chk("br_F_en", {31'd0, F_en}, 32'd1);

      // Forwarding
      next(); idle();
      M_RegWrite = 1'b1; W_RegWrite = 1'b1; M_rd = 5'd7; W_rd = 5'd7; E_ra = 5'd7;
      sample();
      chk("fwdA_M_prio", {30'd0, fwdA}, 32'd2);
      next(); E_ra = 5'd0; M_rd = 5'd0; W_rd = 5'd0; E_rd = 5'd0;
      sample();
      chk("fwdA_x0", {30'd0, fwdA}, 32'd0);
      next(); W_rd = 5'd3; E_rb = 5'd3; M_rd = 5'd4;
      sample();
      chk("fwdB_W", {30'd0, fwdB}, 32'd1);
      next(); M_RegWrite = 1'b0; M_rd = 5'd7; W_rd = 5'd7; E_ra = 5'd7;
      sample();
      chk("fwdA_W_only", {30'd0, fwdA}, 32'd1);

      // Three-cycle freeze with a pending branch, forwarding still active
      next(); idle();
      M_mem_access = 1'b1; mem_ready = 1'b0; E_PCSrc = 1'b1;
      M_RegWrite = 1'b1; M_rd = 5'd7; E_ra = 5'd7;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("frz_F_en", {31'd0, F_en}, 32'd0);
         chk("frz_M_W_en", {31'd0, M_W_en}, 32'd0);
         chk("frz_F_D_flush", {31'd0, F_D_flush}, 32'd0);
         next();
      end
      mem_ready = 1'b1;
      sample();
      chk("rel_F_D_flush", {31'd0, F_D_flush}, 32'd1);
      chk("rel_F_en", {31'd0, F_en}, 32'd1);
      chk("rel_timeout", {31'd0, timeout_err}, 32'd0);

      // Timeout: flag rises after four cycles spent waiting
      next(); idle(); M_mem_access = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         if (i == 4) chk("to_before", {31'd0, timeout_err}, 32'd0);
         next();
      end
      sample();
      chk("to_set", {31'd0, timeout_err}, 32'd1);
      next(); mem_ready = 1'b1;
      next(); M_mem_access = 1'b0;
      sample();
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);

      // Asynchronous reset in the middle of a wait
      next(); M_mem_access = 1'b1; mem_ready = 1'b0;
      E_ra = 5'd7; M_rd = 5'd7; M_RegWrite = 1'b1;
      next(); next();
      sample();
      #2 rst = 1'b1;
      #1;
      chk("arst_F_en", {31'd0, F_en}, 32'd0);
      chk("arst_CTRL_Flush", {31'd0, CTRL_Flush}, 32'd0);
      chk("arst_fwdA", {30'd0, fwdA}, 32'd0);
      chk("arst_timeout", {31'd0, timeout_err}, 32'd0);
      next(); rst = 1'b0; idle();

      // Single-cycle miss
      next(); M_mem_access = 1'b1; mem_ready = 1'b0;
      sample();
      chk("miss_D_E_en", {31'd0, D_E_en}, 32'd0);
      next(); mem_ready = 1'b1;
      sample();
      chk("miss_done_D_E_en", {31'd0, D_E_en}, 32'd1);
      next(); idle();
      next(); next();
      sample();
      chk("final_timeout", {31'd0, timeout_err}, 32'd0);

      run_chk = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
